// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: op modes, FSM states, direction.
package usr_pkg;

  typedef enum logic [1:0] {
    OP_LOG = 2'b00,
    OP_ARI = 2'b01,
    OP_ROT = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_shift_step.sv
// One combinational single-position shift step.
// Rotate fill path exists only when USR_ROTATE_EN is defined; otherwise op=10 is logical.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             dir,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  logic fill;

  always_comb begin
    out_bit = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];
    fill    = serial_in;
    case (op)
      OP_ARI:  fill = (dir == DIR_LEFT) ? serial_in : q[WIDTH-1];
`ifdef USR_ROTATE_EN
      OP_ROT:  fill = out_bit;
`endif
      default: fill = serial_in;
    endcase
    q_next = (dir == DIR_LEFT) ? {q[WIDTH-2:0], fill} : {fill, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load plus multi-position logical/arithmetic/rotate shifts.
// Optional rotate support is enabled by defining USR_ROTATE_EN.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             dir,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  state_e           state_r, state_nx;
  logic [AMT_W-1:0] cnt_r, cnt_nx, amt_sat;
  op_e              op_r;
  logic             dir_r;
  logic             do_shift, capture, done_nx;
  logic [WIDTH-1:0] q_step;
  logic             out_step;

  assign amt_sat = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
  assign busy    = (state_r == S_SHIFT);

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q         (q),
    .op        (op_r),
    .dir       (dir_r),
    .serial_in (serial_in),
    .q_next    (q_step),
    .out_bit   (out_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_nx;
  end

  // load has priority in both states: it suppresses start in IDLE and aborts a shift.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    do_shift = 1'b0;
    capture  = 1'b0;
    done_nx  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!load && start) begin
          capture = 1'b1;
          if (amt_sat == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx = S_SHIFT;
            cnt_nx   = amt_sat;
          end
        end
      end
      S_SHIFT: begin
        if (load) begin
          state_nx = S_IDLE;
        end else begin
          do_shift = 1'b1;
          cnt_nx   = cnt_r - AMT_W'(1);
          if (cnt_r == AMT_W'(1)) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= '0;
      op_r       <= OP_LOG;
      dir_r      <= DIR_RIGHT;
      q          <= '0;
      serial_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt_r <= cnt_nx;
      done  <= done_nx;
      if (capture) begin
        op_r  <= op_e'(op);
        dir_r <= dir;
      end
      if (load) begin
        q <= parallel_in;
      end else if (do_shift) begin
        q          <= q_step;
        serial_out <= out_step;
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=8).
// Expected rotate results follow USR_ROTATE_EN as defined for the build.
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             load;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic [1:0]       op;
  logic             dir;
  logic [AMT_W-1:0] amount;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  universal_shift_register #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .parallel_in (parallel_in),
    .start       (start),
    .op          (op),
    .dir         (dir),
    .amount      (amount),
    .serial_in   (serial_in),
    .q           (q),
    .serial_out  (serial_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] val);
    load = 1'b1;
    parallel_in = val;
    step();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] o, input logic d, input logic [AMT_W-1:0] a);
    start = 1'b1;
    op = o;
    dir = d;
    amount = a;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    load = 1'b0;
    parallel_in = '0;
    start = 1'b0;
    op = 2'b00;
    dir = 1'b0;
    amount = '0;
    serial_in = 1'b0;
    #3;
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sout", serial_out, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // logical right by 3 from 0xA5
    do_load(8'hA5);
    check("ld_a5", q, 8'hA5);
    do_start(2'b00, 1'b0, 4'd3);
    check("lr_busy0", busy, 1'b1);
    check("lr_q0", q, 8'hA5);
    step();
    check("lr_q1", q, 8'h52);
    check("lr_busy1", busy, 1'b1);
    step();
    check("lr_q2", q, 8'h29);
    check("lr_busy2", busy, 1'b1);
    check("lr_done2", done, 1'b0);
    step();
    check("lr_q3", q, 8'h14);
    check("lr_busy3", busy, 1'b0);
    check("lr_done3", done, 1'b1);
    check("lr_sout", serial_out, 1'b1);
    step();
    check("lr_done_pulse", done, 1'b0);

    // arithmetic right by 2; inputs changed after start must not matter
    do_load(8'h90);
    check("sout_hold_load", serial_out, 1'b1);
    do_start(2'b01, 1'b0, 4'd2);
    op = 2'b00;
    dir = 1'b1;
    amount = 4'd7;
    step();
    check("ar_q1", q, 8'hC8);
    step();
    check("ar_q2", q, 8'hE4);
    check("ar_done", done, 1'b1);
    check("ar_busy", busy, 1'b0);
    step();

    // rotate/logical left by 1 from 0x81
    do_load(8'h81);
    do_start(2'b10, 1'b1, 4'd1);
    step();
`ifdef USR_ROTATE_EN
    check("rot_q", q, 8'h03);
`else
    check("rot_q", q, 8'h02);
`endif
    check("rot_sout", serial_out, 1'b1);
    check("rot_done", done, 1'b1);
    step();

    // amount 0: done next cycle, no busy, q unchanged
    do_start(2'b00, 1'b0, 4'd0);
    check("z_done", done, 1'b1);
    check("z_busy", busy, 1'b0);
`ifdef USR_ROTATE_EN
    check("z_q", q, 8'h03);
`else
    check("z_q", q, 8'h02);
`endif

    // start accepted in the done cycle; amount 12 saturates to 8, filling ones
    serial_in = 1'b1;
    do_start(2'b00, 1'b0, 4'd12);
    check("sat_busy0", busy, 1'b1);
    check("sat_done0", done, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) begin
        check("sat_busy_mid", busy, 1'b1);
        check("sat_done_mid", done, 1'b0);
      end
    end
    check("sat_q", q, 8'hFF);
    check("sat_done", done, 1'b1);
    check("sat_busy_end", busy, 1'b0);
    check("sat_sout", serial_out, 1'b0);
    step();
    check("sat_done_pulse", done, 1'b0);

    // reset in the middle of a 5-shift operation
    serial_in = 1'b0;
    do_load(8'hF0);
    do_start(2'b00, 1'b0, 4'd5);
    step();
    step();
    check("mr_q2", q, 8'h3C);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_q", q, 8'h00);
    check("mr_busy", busy, 1'b0);
    check("mr_done", done, 1'b0);
    check("mr_sout", serial_out, 1'b0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mr_no_done", done, 1'b0);
      check("mr_no_busy", busy, 1'b0);
    end

    // start ignored during SHIFT, then load aborts
    do_load(8'hF0);
    do_start(2'b00, 1'b1, 4'd4);
    step();
    check("ab_q1", q, 8'hE0);
    start = 1'b1;
    amount = 4'd1;
    dir = 1'b0;
    step();
    start = 1'b0;
    check("ab_q2", q, 8'hC0);
    check("ab_busy_ign", busy, 1'b1);
    do_load(8'h3C);
    check("ab_q", q, 8'h3C);
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    step();
    check("ab_done_after", done, 1'b0);
    check("ab_q_hold", q, 8'h3C);

    // load and start together in IDLE: load only
    load = 1'b1;
    parallel_in = 8'h5A;
    start = 1'b1;
    amount = 4'd3;
    step();
    load = 1'b0;
    start = 1'b0;
    check("ls_q", q, 8'h5A);
    check("ls_busy", busy, 1'b0);
    check("ls_done", done, 1'b0);
    step();
    check("ls_done2", done, 1'b0);
    check("ls_busy2", busy, 1'b0);
    check("ls_q_hold", q, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set register width; legal range 2..64.
REQ-002 Localparam AMT_W = $clog2(WIDTH+1) SHALL set the width of the shift-amount port.
REQ-003 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 load  in  1  SHALL request a parallel load.
REQ-006 parallel_in  in  WIDTH  SHALL be the parallel load data.
REQ-007 start  in  1  SHALL request a multi-position shift operation.
REQ-008 op  in  2  SHALL select the mode: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
REQ-009 dir  in  1  SHALL select the direction: 0 right, 1 left.
REQ-010 amount  in  AMT_W  SHALL give the number of positions to shift.
REQ-011 serial_in  in  1  SHALL be the fill bit for logical shifts, sampled live on every shift cycle.
REQ-012 q  out  WIDTH  SHALL be the register contents.
REQ-013 serial_out  out  1  SHALL be the bit that left the register on the most recent shift.
REQ-014 busy  out  1  SHALL be high while a shift operation is in progress.
REQ-015 done  out  1  SHALL be a one-cycle pulse marking completion of a shift operation.

Function
REQ-016 FSM SHALL have two states, IDLE and SHIFT; start SHALL be accepted only in IDLE.
REQ-017 On start, op, dir and the amount (saturated to WIDTH) SHALL be captured; later changes to these inputs SHALL have no effect on the running operation.
REQ-018 For N>=1, the N rising edges following the start edge SHALL each perform one shift; busy SHALL be high for exactly those N cycles; done SHALL be high for the single cycle after the Nth shift, with busy low in that cycle.
REQ-019 For N=0, done SHALL pulse in the cycle after start, busy SHALL stay low, and q SHALL be unchanged.
REQ-020 Logical shift: the vacated bit SHALL be filled with serial_in.
REQ-021 Arithmetic shift: right SHALL replicate q[WIDTH-1]; left SHALL equal a logical left shift.
REQ-022 Rotate: the bit shifted out SHALL re-enter at the opposite end.
REQ-023 serial_out SHALL take q[0] on a right shift and q[WIDTH-1] on a left shift; it SHALL hold its value otherwise, including across a load.
REQ-024 In IDLE, load SHALL set q to parallel_in on the next edge; load asserted together with start SHALL win, and start SHALL be dropped with no done.
REQ-025 load during SHIFT SHALL abort the operation: q set to parallel_in, state to IDLE, busy low next cycle, no done.
REQ-026 start during SHIFT SHALL be ignored; start in the done cycle SHALL be accepted.
REQ-027 In IDLE with no load or start, q SHALL hold.

Reset
REQ-028 reset_n low SHALL immediately force q=0, serial_out=0, busy=0, done=0, state=IDLE, including in the middle of an operation; no done SHALL follow the reset.

Configuration
REQ-029 Macro USR_ROTATE_EN defined: op=10 SHALL rotate as in REQ-022.
REQ-030 Macro USR_ROTATE_EN undefined: op=10 SHALL behave as a logical shift (REQ-020) and no rotate logic SHALL be synthesised.

Structure
REQ-031 Package usr_pkg SHALL hold the op encoding enum (OP_LOG, OP_ARI, OP_ROT, OP_RSV), the FSM state enum, and the direction constants.
REQ-032 Sub-module usr_shift_step SHALL implement one combinational single-position step (inputs q, op, dir, serial_in; outputs next q, out bit); the top level SHALL hold the FSM, the down-counter and the registers.

Verification (WIDTH=8)
REQ-033 Load 0xA5, then start op=00 dir=0 amount=3 serial_in=0 -> q=0x52, 0x29, 0x14; busy high 3 cycles; done pulses once; serial_out=1.
REQ-034 Load 0x90, then op=01 dir=0 amount=2 -> q=0xC8, then 0xE4; done pulses.
REQ-035 Load 0x81, then op=10 dir=1 amount=1 -> q=0x03, serial_out=1 with USR_ROTATE_EN; q=0x02 (serial_in=0) without it.
REQ-036 amount=0 -> done the next cycle, busy never high, q unchanged; load 0x00, amount=12, op=00 dir=0 serial_in=1 -> 8 shifts, q=0xFF, then done.
REQ-037 amount=5; reset_n low after 2 shifts -> q=0x00, busy=0, done never asserted.
REQ-038 start during SHIFT -> ignored; load 0x3C during SHIFT -> q=0x3C, busy low next cycle, no done; load and start together in IDLE -> load only, no done.
